sram_controller: RTL and testbench

Wishbone classic/registered-feedback slave driving an external asynchronous 32-bit SRAM. It sits directly downstream of the 3-way Wishbone arbiter and consumes its master-side bus (adr/dat/cyc/stb/cti/sel/we, returning dat and ack). Programmable wait states cover SRAM access time. Incrementing-burst reads (cti 3'b010) are pipelined so that back-to-back beats need no idle cycle.

---
 rtl/sram_controller.sv | 128 ++++++++++++
 tb/tb_sram_controller.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// Wishbone slave for an asynchronous 32-bit SRAM with programmable wait states.
// Incrementing-burst reads chain ACK -> READ directly, so no idle cycle separates beats.
module sram_controller #(
  parameter int ADDR_WIDTH = 18,
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 2
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic [31:0]           adr_i,
  input  logic [31:0]           dat_i,
  output logic [31:0]           dat_o,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  output logic                  ack_o,
  input  logic [2:0]            cti_i,
  input  logic [3:0]            sel_i,
  input  logic                  we_i,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [31:0]           sram_data_o,
  input  logic [31:0]           sram_data_i,
  output logic                  sram_data_oe_o,
  output logic                  sram_ce_n_o,
  output logic                  sram_oe_n_o,
  output logic                  sram_we_n_o,
  output logic [3:0]            sram_be_n_o,
  output logic [1:0]            dbg_state_o
);

  // Bus handshake: a request is taken in IDLE when cyc_i & stb_i are both high;
  // ack_o pulses for one cycle per beat, and the master must hold cyc_i/we_i/cti_i
  // stable through the ack cycle because the burst decision is made there.

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, ACK = 2'd3} state_t;

  localparam logic [3:0] RD_LAST = 4'(READ_WAIT - 1);
  localparam logic [3:0] WR_LAST = 4'(WRITE_WAIT - 1);

  state_t     state, next_state;
  logic [3:0] wcnt, wcnt_next;
  logic       wr_q, wr_next;
  logic       capture, addr_load, addr_inc;

  logic unused_adr;
  assign unused_adr  = &{1'b0, adr_i[31:ADDR_WIDTH+2], adr_i[1:0]};
  assign dbg_state_o = state;

  always_comb begin
    next_state = state;
    wcnt_next  = wcnt;
    wr_next    = wr_q;
    capture    = 1'b0;
    addr_load  = 1'b0;
    addr_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (cyc_i && stb_i) begin
          addr_load  = 1'b1;
          wcnt_next  = 4'd0;
          wr_next    = we_i;
          next_state = we_i ? WRITE : READ;
        end
      end
      READ: begin
        if (!cyc_i) begin
          next_state = IDLE;
        end else if (wcnt >= RD_LAST) begin
          // Data is recaptured every stalled cycle so dat_o is fresh when stb_i returns.
          capture = 1'b1;
          if (stb_i) next_state = ACK;
        end else begin
          wcnt_next = wcnt + 4'd1;
        end
      end
      WRITE: begin
        if (wcnt == WR_LAST) next_state = ACK;
        else                 wcnt_next  = wcnt + 4'd1;
      end
      ACK: begin
        if (!wr_q && cyc_i && !we_i && cti_i == 3'b010) begin
          addr_inc   = 1'b1;
          wcnt_next  = 4'd0;
          next_state = READ;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state          <= IDLE;
      wcnt           <= 4'd0;
      wr_q           <= 1'b0;
      ack_o          <= 1'b0;
      dat_o          <= 32'd0;
      sram_addr_o    <= '0;
      sram_data_o    <= 32'd0;
      sram_data_oe_o <= 1'b0;
      sram_ce_n_o    <= 1'b1;
      sram_oe_n_o    <= 1'b1;
      sram_we_n_o    <= 1'b1;
      sram_be_n_o    <= 4'hF;
    end else begin
      state <= next_state;
      wcnt  <= wcnt_next;
      wr_q  <= wr_next;
      ack_o <= (next_state == ACK);
      if (capture) dat_o <= sram_data_i;
      if (addr_load) begin
        sram_addr_o <= adr_i[ADDR_WIDTH+1:2];
        if (we_i) sram_data_o <= dat_i;
      end else if (addr_inc) begin
        sram_addr_o <= sram_addr_o + 1'b1;
      end
      // Strobes are registered from the upcoming state so each state sees its own pad values.
      sram_ce_n_o    <= (next_state == IDLE);
      sram_oe_n_o    <= !(next_state == READ || (next_state == ACK && !wr_next));
      sram_we_n_o    <= (next_state != WRITE);
      sram_data_oe_o <= wr_next && (next_state == WRITE || next_state == ACK);
      if (next_state == IDLE)  sram_be_n_o <= 4'hF;
      else if (addr_load)      sram_be_n_o <= we_i ? ~sel_i : 4'h0;
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a behavioural asynchronous SRAM attached.
// Cycle n of a transfer is the clock period after the n-th edge following the request edge.
module tb_sram_controller;
  localparam int AW = 18;

  logic          clk = 1'b0;
  logic          reset_i;
  logic [31:0]   adr_i, dat_i, dat_o;
  logic          cyc_i, stb_i, ack_o, we_i;
  logic [2:0]    cti_i;
  logic [3:0]    sel_i;
  logic [AW-1:0] sram_addr_o;
  logic [31:0]   sram_data_o, sram_data_i;
  logic          sram_data_oe_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o;
  logic [3:0]    sram_be_n_o;
  logic [1:0]    dbg_state_o;

  int n_cmp = 0;
  int n_err = 0;

  sram_controller #(.ADDR_WIDTH(AW), .READ_WAIT(2), .WRITE_WAIT(2)) dut (
    .clock_i(clk), .reset_i(reset_i), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
    .cyc_i(cyc_i), .stb_i(stb_i), .ack_o(ack_o), .cti_i(cti_i), .sel_i(sel_i), .we_i(we_i),
    .sram_addr_o(sram_addr_o), .sram_data_o(sram_data_o), .sram_data_i(sram_data_i),
    .sram_data_oe_o(sram_data_oe_o), .sram_ce_n_o(sram_ce_n_o), .sram_oe_n_o(sram_oe_n_o),
    .sram_we_n_o(sram_we_n_o), .sram_be_n_o(sram_be_n_o), .dbg_state_o(dbg_state_o)
  );

  always #5 clk = ~clk;

  // External SRAM: combinational read, byte-lane write while ce_n and we_n are low.
  logic [31:0] mem [0:(1<<AW)-1];
  assign sram_data_i = (!sram_ce_n_o && !sram_oe_n_o) ? mem[sram_addr_o] : 32'h0;
  always @(posedge clk) begin
    if (!sram_ce_n_o && !sram_we_n_o && sram_data_oe_o)
      for (int i = 0; i < 4; i++)
        if (!sram_be_n_o[i]) mem[sram_addr_o][8*i +: 8] <= sram_data_o[8*i +: 8];
  end

  // Master driver state
  logic [2:0] cti_q[$];
  int         ack_cyc[$];
  int         cyc_no;
  logic       prev_ack;

  task automatic idle_bus();
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; cti_i = 3'b000;
  endtask

  task automatic start_req(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] s, input logic [2:0] c);
    adr_i = a; we_i = w; dat_i = d; sel_i = s; cti_i = c; cyc_i = 1'b1; stb_i = 1'b1;
    cyc_no = 0; prev_ack = 1'b0; ack_cyc.delete();
  endtask

  // One clock; once an ack cycle has closed, present the next beat's cti or release the bus.
  task automatic step();
    @(posedge clk); #1;
    cyc_no++;
    if (prev_ack) begin
      if (cti_q.size() > 0) cti_i = cti_q.pop_front();
      else idle_bus();
    end
    prev_ack = ack_o;
    if (ack_o) ack_cyc.push_back(cyc_no);
  endtask

  task automatic test_reset();
    logic [62:0] got, exp;
    exp = {1'b0, 32'h0, 18'h0, 1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 2'd0, 1'b0, 1'b0};
    got = {ack_o, dat_o, sram_addr_o, sram_data_oe_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o,
           sram_be_n_o, dbg_state_o, |sram_data_o, 1'b0};
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL reset_state got %h exp %h", got, exp); end
    reset_i = 1'b0;
    step();
    step();
    got = {ack_o, dat_o, sram_addr_o, sram_data_oe_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o,
           sram_be_n_o, dbg_state_o, |sram_data_o, 1'b0};
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL idle_after_reset got %h exp %h", got, exp); end
  endtask

  task automatic test_single_read();
    start_req(32'h40, 1'b0, 32'h0, 4'hF, 3'b000);
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c == 1) begin
        n_cmp++;
        if (sram_addr_o !== 18'h10 || sram_ce_n_o !== 1'b0 || sram_oe_n_o !== 1'b0 ||
            sram_be_n_o !== 4'h0 || sram_data_oe_o !== 1'b0) begin
          n_err++;
          $display("FAIL read_pads addr %h ce %b oe %b be %b doe %b exp addr 10 ce0 oe0 be0 doe0",
                   sram_addr_o, sram_ce_n_o, sram_oe_n_o, sram_be_n_o, sram_data_oe_o);
        end
      end
      if (c == 3) begin
        n_cmp++;
        if (ack_o !== 1'b1 || dat_o !== 32'hDEADBEEF) begin
          n_err++; $display("FAIL read_data ack %b dat %h exp 1 deadbeef", ack_o, dat_o);
        end
      end
    end
    n_cmp++;
    if (ack_cyc.size() != 1 || ack_cyc[0] != 3 || dbg_state_o !== 2'd0) begin
      n_err++;
      $display("FAIL read_ack_timing acks %0d first %0d state %0d exp 1 at 3 state 0",
               ack_cyc.size(), (ack_cyc.size() > 0) ? ack_cyc[0] : -1, dbg_state_o);
    end
  endtask

  task automatic test_stalled_read();
    start_req(32'h40, 1'b0, 32'h0, 4'hF, 3'b000);
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 1) stb_i = 1'b0;
      if (c == 5) stb_i = 1'b1;
      if (c == 6) begin
        n_cmp++;
        if (ack_o !== 1'b1 || dat_o !== 32'hDEADBEEF) begin
          n_err++; $display("FAIL stall_data ack %b dat %h exp 1 deadbeef", ack_o, dat_o);
        end
      end
    end
    n_cmp++;
    if (ack_cyc.size() != 1 || ack_cyc[0] != 6) begin
      n_err++;
      $display("FAIL stall_ack acks %0d first %0d exp 1 at 6", ack_cyc.size(),
               (ack_cyc.size() > 0) ? ack_cyc[0] : -1);
    end
  endtask

  task automatic test_byte_write();
    logic exp_we_n, exp_doe;
    start_req(32'h100, 1'b1, 32'h12345678, 4'b0011, 3'b000);
    for (int c = 1; c <= 5; c++) begin
      step();
      exp_we_n = !(c == 1 || c == 2);
      exp_doe  = (c >= 1 && c <= 3);
      n_cmp++;
      if (sram_we_n_o !== exp_we_n || sram_data_oe_o !== exp_doe) begin
        n_err++;
        $display("FAIL write_strobes c=%0d we_n %b doe %b exp %b %b", c, sram_we_n_o,
                 sram_data_oe_o, exp_we_n, exp_doe);
      end
      if (c == 1) begin
        n_cmp++;
        if (sram_be_n_o !== 4'b1100 || sram_addr_o !== 18'h40 || sram_data_o !== 32'h12345678) begin
          n_err++;
          $display("FAIL write_lanes be_n %b addr %h data %h exp 1100 40 12345678",
                   sram_be_n_o, sram_addr_o, sram_data_o);
        end
      end
    end
    n_cmp++;
    if (ack_cyc.size() != 1 || ack_cyc[0] != 3) begin
      n_err++;
      $display("FAIL write_ack acks %0d first %0d exp 1 at 3", ack_cyc.size(),
               (ack_cyc.size() > 0) ? ack_cyc[0] : -1);
    end
    start_req(32'h100, 1'b0, 32'h0, 4'hF, 3'b000);
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c == 3) begin
        n_cmp++;
        if (ack_o !== 1'b1 || dat_o !== 32'hAABB5678) begin
          n_err++; $display("FAIL write_readback ack %b dat %h exp 1 aabb5678", ack_o, dat_o);
        end
      end
    end
  endtask

  task automatic test_burst_read();
    int exp_acks[4] = '{3, 6, 9, 12};
    start_req(32'h200, 1'b0, 32'h0, 4'hF, 3'b010);
    cti_q = '{3'b010, 3'b010, 3'b111};
    for (int c = 1; c <= 14; c++) begin
      step();
      if (c % 3 == 1 && c <= 10) begin
        n_cmp++;
        if (sram_addr_o !== 18'(18'h80 + (c - 1) / 3)) begin
          n_err++;
          $display("FAIL burst_addr c=%0d got %h exp %h", c, sram_addr_o, 18'(18'h80 + (c - 1) / 3));
        end
      end
      if (c % 3 == 0 && c <= 12) begin
        n_cmp++;
        if (ack_o !== 1'b1 || dat_o !== 32'h10000000 + 32'((c / 3) - 1)) begin
          n_err++;
          $display("FAIL burst_data c=%0d ack %b dat %h exp 1 %h", c, ack_o, dat_o,
                   32'h10000000 + 32'((c / 3) - 1));
        end
      end
      if (c == 13) begin
        n_cmp++;
        if (dbg_state_o !== 2'd0 || sram_ce_n_o !== 1'b1) begin
          n_err++; $display("FAIL burst_end state %0d ce_n %b exp 0 1", dbg_state_o, sram_ce_n_o);
        end
      end
    end
    n_cmp++;
    if (ack_cyc.size() != 4 || ack_cyc[0] != exp_acks[0] || ack_cyc[1] != exp_acks[1] ||
        ack_cyc[2] != exp_acks[2] || ack_cyc[3] != exp_acks[3]) begin
      n_err++; $display("FAIL burst_ack_count got %0d acks exp 4 at 3,6,9,12", ack_cyc.size());
    end
  endtask

  task automatic test_burst_abort();
    start_req(32'h80, 1'b0, 32'h0, 4'hF, 3'b010);
    cti_q = '{3'b010, 3'b010};
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 4) begin
        cyc_i = 1'b0; stb_i = 1'b0; cti_q.delete();
      end
      if (c == 5) begin
        n_cmp++;
        if ({sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o, dbg_state_o} !== {3'b111, 4'hF, 2'd0}) begin
          n_err++;
          $display("FAIL abort_strobes ce %b oe %b we %b be %b state %0d exp 1 1 1 f 0",
                   sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o, dbg_state_o);
        end
      end
    end
    n_cmp++;
    if (ack_cyc.size() != 1) begin
      n_err++; $display("FAIL abort_acks got %0d exp 1", ack_cyc.size());
    end
  endtask

  task automatic test_burst_wrap();
    start_req(32'h000FFFFC, 1'b0, 32'h0, 4'hF, 3'b010);
    cti_q = '{3'b111};
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 1 || c == 4) begin
        n_cmp++;
        if (sram_addr_o !== ((c == 1) ? 18'h3FFFF : 18'h0)) begin
          n_err++; $display("FAIL wrap_addr c=%0d got %h", c, sram_addr_o);
        end
      end
      if (c == 6) begin
        n_cmp++;
        if (ack_o !== 1'b1 || dat_o !== 32'h5A5A0002) begin
          n_err++; $display("FAIL wrap_data ack %b dat %h exp 1 5a5a0002", ack_o, dat_o);
        end
      end
    end
    n_cmp++;
    if (ack_cyc.size() != 2) begin
      n_err++; $display("FAIL wrap_acks got %0d exp 2", ack_cyc.size());
    end
  endtask

  task automatic test_reset_mid_write();
    start_req(32'h300, 1'b1, 32'hCAFEF00D, 4'hF, 3'b000);
    step();
    reset_i = 1'b1;
    idle_bus();
    step();
    n_cmp++;
    if ({sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o, sram_data_oe_o, ack_o, dbg_state_o} !==
        {3'b111, 4'hF, 1'b0, 1'b0, 2'd0}) begin
      n_err++;
      $display("FAIL reset_mid_write ce %b oe %b we %b be %b doe %b ack %b state %0d exp 1 1 1 f 0 0 0",
               sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o, sram_data_oe_o, ack_o, dbg_state_o);
    end
    reset_i = 1'b0;
    step();
    start_req(32'h40, 1'b0, 32'h0, 4'hF, 3'b000);
    for (int c = 1; c <= 5; c++) step();
    n_cmp++;
    if (ack_cyc.size() != 1 || ack_cyc[0] != 3 || dat_o !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL read_after_reset acks %0d dat %h exp 1 at 3 deadbeef", ack_cyc.size(), dat_o);
    end
  endtask

  task automatic test_back_to_back();
    start_req(32'h104, 1'b1, 32'h0F0F1234, 4'hF, 3'b000);
    for (int c = 1; c <= 3; c++) step();
    n_cmp++;
    if (ack_o !== 1'b1 || sram_data_oe_o !== 1'b1 || sram_oe_n_o !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_write_ack ack %b doe %b oe_n %b exp 1 1 1", ack_o, sram_data_oe_o, sram_oe_n_o);
    end
    step();
    n_cmp++;
    if (sram_data_oe_o !== 1'b0 || sram_oe_n_o !== 1'b1) begin
      n_err++; $display("FAIL b2b_gap doe %b oe_n %b exp 0 1", sram_data_oe_o, sram_oe_n_o);
    end
    start_req(32'h104, 1'b0, 32'h0, 4'hF, 3'b000);
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c == 1) begin
        n_cmp++;
        if (sram_oe_n_o !== 1'b0 || sram_data_oe_o !== 1'b0) begin
          n_err++; $display("FAIL b2b_read_start oe_n %b doe %b exp 0 0", sram_oe_n_o, sram_data_oe_o);
        end
      end
      if (c == 3) begin
        n_cmp++;
        if (ack_o !== 1'b1 || dat_o !== 32'h0F0F1234) begin
          n_err++; $display("FAIL b2b_read_data ack %b dat %h exp 1 0f0f1234", ack_o, dat_o);
        end
      end
    end
  endtask

  initial begin
    reset_i = 1'b1;
    adr_i = 32'h0; dat_i = 32'h0; sel_i = 4'h0;
    idle_bus();
    prev_ack = 1'b0; cyc_no = 0;
    mem[18'h10]    = 32'hDEADBEEF;
    mem[18'h40]    = 32'hAABBCCDD;
    mem[18'h41]    = 32'h0;
    for (int k = 0; k < 4; k++) mem[18'h80 + k] = 32'h10000000 + 32'(k);
    mem[18'h3FFFF] = 32'hA5A50001;
    mem[18'h0]     = 32'h5A5A0002;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_single_read();
    test_stalled_read();
    test_byte_write();
    test_burst_read();
    test_burst_abort();
    test_burst_wrap();
    test_reset_mid_write();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
